// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM arbiter: FSM states, port index
// and the latched controller command.
package sdram_arb_pkg;

    localparam int ARB_ADDR_W = 24;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_MASK_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    // 0 = CPU bus bridge, 1 = SD/SPI DMA
    typedef logic port_idx_t;

    // Command as captured from the winning port; the field widths follow
    // the package widths, which the top-level parameters default to.
    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_MASK_W-1:0] wmask;
    } arb_cmd_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Native command port between the arbiter (master) and the SDRAM
// controller (slave).
interface sdram_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [MASK_W-1:0] o_mem_wmask;
    logic              i_mem_ack;
    logic              i_mem_rvalid;
    logic [DATA_W-1:0] i_mem_rdata;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        input  i_mem_ack, i_mem_rvalid, i_mem_rdata
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        output i_mem_ack, i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie
// goes to the port that was not granted last.
module rr_pick2
    import sdram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last,
    output logic       valid,
    output port_idx_t  idx
);

    // Pick the winner from the request pair and the last-grant pointer
    always_comb begin
        valid = |req;
        if (&req) begin
            idx = ~last;
        end else begin
            idx = req[1];
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between the CPU bridge
// (port 0) and the block-transfer DMA (port 1). One transaction in flight;
// the winning command is latched once and all outputs are registered.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [MASK_W-1:0] p0_wmask,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [MASK_W-1:0] p1_wmask,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,

    sdram_arbiter_if.master   mem,

    output logic              o_grant,
    output logic              o_busy
);

    arb_state_t              state_q, state_d;
    arb_cmd_t                cmd_q, cmd_d;
    port_idx_t               grant_q, grant_d;
    port_idx_t               last_q, last_d;
    logic                    mem_req_q, mem_req_d;
    logic                    busy_q, busy_d;
    logic [1:0]              ack_q, ack_d;
    logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;

    arb_cmd_t                port_cmd [2];
    logic [1:0]              req_vec;
    logic                    pick_valid;
    port_idx_t               pick_idx;

    assign req_vec     = {p1_req, p0_req};
    assign port_cmd[0] = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, wmask: p0_wmask};
    assign port_cmd[1] = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, wmask: p1_wmask};

    rr_pick2 u_pick (
        .req   (req_vec),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and next-output logic for the transaction FSM
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        grant_d   = grant_q;
        last_d    = last_q;
        ack_d     = 2'b00;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    cmd_d   = port_cmd[pick_idx];
                    grant_d = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem.i_mem_ack) begin
                    if (cmd_q.we) begin
                        ack_d[grant_q] = 1'b1;
                        state_d        = DONE;
                    end else begin
                        state_d        = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (mem.i_mem_rvalid) begin
                    rdata_d[grant_q] = mem.i_mem_rdata;
                    ack_d[grant_q]   = 1'b1;
                    state_d          = DONE;
                end
            end
            DONE: begin
                // Requests are not looked at here, so the pointer update
                // is in place before the next IDLE pick.
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_req_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
    end

    // State and registered outputs; last-grant pointer resets to port 1
    // so port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            mem_req_q <= mem_req_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign mem.o_mem_req   = mem_req_q;
    assign mem.o_mem_we    = cmd_q.we;
    assign mem.o_mem_addr  = cmd_q.addr;
    assign mem.o_mem_wdata = cmd_q.wdata;
    assign mem.o_mem_wmask = cmd_q.wmask;

    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];
    assign o_grant  = grant_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: writes, stalled read, round-robin
// alternation, spurious controller strobes, mid-read reset, late command
// changes. Inputs change 1 ns after the rising edge; outputs are sampled
// there as well.
module tb_sdram_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic [MASK_W-1:0] p0_wmask, p1_wmask;
    logic              p0_ack, p1_ack;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              o_grant, o_busy;

    int tests_run = 0;
    int tests_failed = 0;

    sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .p0_req   (p0_req),
        .p0_we    (p0_we),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_wmask (p0_wmask),
        .p0_ack   (p0_ack),
        .p0_rdata (p0_rdata),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_wmask (p1_wmask),
        .p1_ack   (p1_ack),
        .p1_rdata (p1_rdata),
        .mem      (mem_if),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_wmask = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_wmask = '0;
        mem_if.i_mem_ack = 0; mem_if.i_mem_rvalid = 0; mem_if.i_mem_rdata = '0;
        tick; tick;

        // ---- reset state
        check("rst_busy",    o_busy, 0);
        check("rst_memreq",  mem_if.o_mem_req, 0);
        check("rst_grant",   o_grant, 0);
        check("rst_acks",    {p0_ack, p1_ack}, 0);
        check("rst_addr",    mem_if.o_mem_addr, 0);
        reset = 1'b0;
        tick;

        // ---- single p0 write, controller acks in first ISSUE cycle
        p0_req = 1; p0_we = 1; p0_addr = 24'h000010; p0_wdata = 32'hDEADBEEF; p0_wmask = 4'hF;
        mem_if.i_mem_ack = 1;
        tick;                                   // cycle 1: ISSUE
        check("wr_memreq_c1", mem_if.o_mem_req, 1);
        check("wr_we",        mem_if.o_mem_we, 1);
        check("wr_addr",      mem_if.o_mem_addr, 64'h10);
        check("wr_wdata",     mem_if.o_mem_wdata, 64'hDEADBEEF);
        check("wr_wmask",     mem_if.o_mem_wmask, 64'hF);
        check("wr_p0ack_c1",  p0_ack, 0);
        tick;                                   // cycle 2: DONE
        check("wr_memreq_c2", mem_if.o_mem_req, 0);
        check("wr_p0ack_c2",  p0_ack, 1);
        check("wr_p1ack_c2",  p1_ack, 0);
        p0_req = 0;
        tick;                                   // cycle 3: IDLE
        check("wr_p0ack_c3",  p0_ack, 0);
        check("wr_idle_c3",   o_busy, 0);
        mem_if.i_mem_ack = 0;

        // ---- spurious rvalid in IDLE
        mem_if.i_mem_rvalid = 1; mem_if.i_mem_rdata = 32'h22222222;
        tick;
        check("sp_idle_acks",  {p0_ack, p1_ack}, 0);
        check("sp_idle_rd0",   p0_rdata, 0);
        check("sp_idle_rd1",   p1_rdata, 0);
        check("sp_idle_busy",  o_busy, 0);
        mem_if.i_mem_rvalid = 0;

        // ---- p1 read, 3 stall cycles, data 5 cycles after ack
        p1_req = 1; p1_we = 0; p1_addr = 24'h123456;
        tick;                                   // ISSUE stall 1
        check("rd_memreq",  mem_if.o_mem_req, 1);
        check("rd_grant",   o_grant, 1);
        check("rd_addr",    mem_if.o_mem_addr, 64'h123456);
        check("rd_we",      mem_if.o_mem_we, 0);
        mem_if.i_mem_rvalid = 1; mem_if.i_mem_rdata = 32'h11111111;
        tick;                                   // ISSUE stall 2 (spurious rvalid sampled)
        mem_if.i_mem_rvalid = 0;
        tick;                                   // ISSUE stall 3
        check("sp_issue_acks", {p0_ack, p1_ack}, 0);
        check("sp_issue_rd1",  p1_rdata, 0);
        check("rd_stall_req",  mem_if.o_mem_req, 1);
        mem_if.i_mem_ack = 1;
        tick;                                   // WAIT_RD
        mem_if.i_mem_ack = 0;
        check("rd_wait_memreq", mem_if.o_mem_req, 0);
        check("rd_wait_busy",   o_busy, 1);
        repeat (4) tick;
        mem_if.i_mem_rvalid = 1; mem_if.i_mem_rdata = 32'hCAFEF00D;
        tick;                                   // DONE
        mem_if.i_mem_rvalid = 0;
        check("rd_p1ack",   p1_ack, 1);
        check("rd_p1rdata", p1_rdata, 64'hCAFEF00D);
        check("rd_p0ack",   p0_ack, 0);
        check("rd_p0rdata", p0_rdata, 0);
        p1_req = 0;
        tick;                                   // IDLE
        check("rd_p1ack_drop", p1_ack, 0);
        check("rd_p1rd_hold",  p1_rdata, 64'hCAFEF00D);

        // ---- both ports requesting for 6 transactions (last grant = 1 now)
        p0_req = 1; p0_we = 1; p0_addr = 24'h000100; p0_wdata = 32'h0A0A0A0A; p0_wmask = 4'h3;
        p1_req = 1; p1_we = 1; p1_addr = 24'h000200; p1_wdata = 32'h0B0B0B0B; p1_wmask = 4'hC;
        mem_if.i_mem_ack = 1;
        for (int k = 0; k < 6; k++) begin
            tick;                               // ISSUE
            check($sformatf("rr%0d_grant", k), o_grant, k % 2);
            check($sformatf("rr%0d_addr", k), mem_if.o_mem_addr, (k % 2) ? 64'h200 : 64'h100);
            tick;                               // DONE
            check($sformatf("rr%0d_acks", k), {p1_ack, p0_ack}, (k % 2) ? 2'b10 : 2'b01);
            tick;                               // IDLE
        end
        p0_req = 0; p1_req = 0;
        mem_if.i_mem_ack = 0;
        tick;

        // ---- p0 changes address while in ISSUE
        p0_req = 1; p0_we = 1; p0_addr = 24'h000AAA; p0_wdata = 32'h12345678; p0_wmask = 4'h1;
        tick;                                   // ISSUE
        p0_addr = 24'h000BBB; p0_wdata = 32'h87654321;
        tick;
        check("chg_addr",  mem_if.o_mem_addr, 64'hAAA);
        check("chg_wdata", mem_if.o_mem_wdata, 64'h12345678);
        mem_if.i_mem_ack = 1;
        tick;                                   // DONE
        check("chg_p0ack", p0_ack, 1);
        p0_req = 0;
        tick;                                   // IDLE, last grant = 0

        // ---- reset during WAIT_RD
        p0_req = 1; p0_we = 0; p0_addr = 24'h000055;
        tick;                                   // ISSUE
        tick;                                   // WAIT_RD
        check("mr_wait_busy", o_busy, 1);
        p0_req = 0; mem_if.i_mem_ack = 0;
        reset = 1'b1;
        tick;
        check("mr_busy",   o_busy, 0);
        check("mr_grant",  o_grant, 0);
        check("mr_memreq", mem_if.o_mem_req, 0);
        check("mr_cmd",    {mem_if.o_mem_we, mem_if.o_mem_addr, mem_if.o_mem_wdata}, 0);
        check("mr_wmask",  mem_if.o_mem_wmask, 0);
        check("mr_acks",   {p0_ack, p1_ack}, 0);
        check("mr_rdata",  {p0_rdata, p1_rdata}, 0);
        reset = 1'b0;
        p0_req = 1; p0_we = 1; p0_addr = 24'h000300; p0_wdata = 32'h33333333; p0_wmask = 4'hF;
        p1_req = 1; p1_we = 1; p1_addr = 24'h000400; p1_wdata = 32'h44444444; p1_wmask = 4'hF;
        mem_if.i_mem_ack = 1;
        tick;                                   // ISSUE
        check("mr_tie_grant", o_grant, 0);
        check("mr_tie_addr",  mem_if.o_mem_addr, 64'h300);
        tick;                                   // DONE
        check("mr_tie_acks",  {p1_ack, p0_ack}, 2'b01);
        p0_req = 0; p1_req = 0; mem_if.i_mem_ack = 0;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
